// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT frame arbiter.
// Imported by the arbiter top and its tag FIFO.
package fft_pkg;

    localparam int SAMPLE_W  = 50;
    localparam int FRAME_LEN = 8;
    localparam int TAG_DEPTH = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/fft_tag_fifo.sv
// Tag FIFO: remembers which requester owns each frame inside the core.
// One bit wide, pointers wrap modulo DEPTH.
module fft_tag_fifo
    import fft_pkg::*;
#(
    parameter int DEPTH = fft_pkg::TAG_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          din,
    output logic          dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter in front of a shared FFT core.
// Whole frames are granted atomically; results are routed back by tag.
module fft_frame_arbiter
    import fft_pkg::*;
#(
    parameter int FRAME_LEN = fft_pkg::FRAME_LEN,
    parameter int TAG_DEPTH = fft_pkg::TAG_DEPTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SAMPLE_W-1:0] req0_signal_i,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [SAMPLE_W-1:0] req1_signal_i,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    output logic [SAMPLE_W-1:0] core_signal_o,
    output logic                core_valid_o,
    input  logic                core_ready_i,
    input  logic [SAMPLE_W-1:0] core_signal_i,
    input  logic                core_valid_i,
    output logic                core_ready_o,
    output logic [SAMPLE_W-1:0] res_signal_o,
    output logic                res_valid_o,
    output logic                res_id_o,
    input  logic                res_ready_i,
    output logic                busy_o
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(TAG_DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    state_t        state;
    state_t        state_nx;
    logic          pref;
    logic          owner;
    logic          grant;
    logic          grant_id;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          streaming;
    logic          src_valid;
    logic          in_beat;
    logic          in_last;
    logic          out_beat;
    logic          tag_pop;
    logic          tag_full;
    logic          tag_empty;
    logic          tag_head;
    logic [TW-1:0] tag_count;

    assign streaming     = (state == STREAM);
    assign src_valid     = owner ? req1_valid_i : req0_valid_i;
    assign core_signal_o = owner ? req1_signal_i : req0_signal_i;
    assign core_valid_o  = streaming && src_valid;
    assign req0_ready_o  = streaming && !owner && core_ready_i;
    assign req1_ready_o  = streaming && owner && core_ready_i;

    assign in_beat = core_valid_o && core_ready_i;
    assign in_last = in_beat && (in_cnt == LAST);

    assign res_signal_o = core_signal_i;
    assign res_valid_o  = core_valid_i && !tag_empty;
    assign core_ready_o = res_ready_i && !tag_empty;
    assign res_id_o     = tag_head;

    assign out_beat = res_valid_o && res_ready_i;
    assign tag_pop  = out_beat && (out_cnt == LAST);

    assign busy_o = streaming || (tag_count != '0);

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_id = pref;
        unique case (state)
            IDLE: begin
                if (!tag_full) begin
                    if (pref ? req1_valid_i : req0_valid_i) begin
                        grant    = 1'b1;
                        grant_id = pref;
                    end else if (pref ? req0_valid_i : req1_valid_i) begin
                        grant    = 1'b1;
                        grant_id = ~pref;
                    end
                end
                if (grant) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (in_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pref    <= 1'b0;
            owner   <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner <= grant_id;
            end
            if (in_beat) begin
                in_cnt <= in_last ? '0 : in_cnt + 1'b1;
            end
            // Round robin favours whoever did not own the frame just finished.
            if (in_last) begin
                pref <= ~owner;
            end
            if (out_beat) begin
                out_cnt <= tag_pop ? '0 : out_cnt + 1'b1;
            end
        end
    end

    fft_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .CW    (TW)
    ) u_tags (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (grant),
        .pop   (tag_pop),
        .din   (grant_id),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter: arbitration, atomic frames,
// tag FIFO back-pressure, result routing and mid-frame reset.
module tb_fft_frame_arbiter;
    import fft_pkg::*;

    localparam logic [SAMPLE_W-1:0] S0 = 50'h0_1111_0000_0000;
    localparam logic [SAMPLE_W-1:0] S1 = 50'h2_2222_0000_0000;
    localparam logic [SAMPLE_W-1:0] RS = 50'h1_5555_0000_0000;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [SAMPLE_W-1:0] req0_signal_i;
    logic                req0_valid_i;
    logic                req0_ready_o;
    logic [SAMPLE_W-1:0] req1_signal_i;
    logic                req1_valid_i;
    logic                req1_ready_o;
    logic [SAMPLE_W-1:0] core_signal_o;
    logic                core_valid_o;
    logic                core_ready_i;
    logic [SAMPLE_W-1:0] core_signal_i;
    logic                core_valid_i;
    logic                core_ready_o;
    logic [SAMPLE_W-1:0] res_signal_o;
    logic                res_valid_o;
    logic                res_id_o;
    logic                res_ready_i;
    logic                busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    fft_frame_arbiter dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req0_signal_i (req0_signal_i),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req1_signal_i (req1_signal_i),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .core_signal_o (core_signal_o),
        .core_valid_o  (core_valid_o),
        .core_ready_i  (core_ready_i),
        .core_signal_i (core_signal_i),
        .core_valid_i  (core_valid_i),
        .core_ready_o  (core_ready_o),
        .res_signal_o  (res_signal_o),
        .res_valid_o   (res_valid_o),
        .res_id_o      (res_id_o),
        .res_ready_i   (res_ready_i),
        .busy_o        (busy_o)
    );

    task automatic quiet_inputs();
        req0_valid_i  = 1'b0;
        req1_valid_i  = 1'b0;
        core_ready_i  = 1'b0;
        core_valid_i  = 1'b0;
        res_ready_i   = 1'b0;
        req0_signal_i = S0;
        req1_signal_i = S1;
        core_signal_i = RS;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        quiet_inputs();
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        core_ready_i = 1'b1;
        core_valid_i = 1'b1;
        res_ready_i  = 1'b1;
        @(negedge clk_i);
        #1;
        n_cmp++;
        if ({core_valid_o, req0_ready_o, req1_ready_o,
             res_valid_o, core_ready_o, busy_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b%b%b%b%b%b want=000000",
                     core_valid_o, req0_ready_o, req1_ready_o,
                     res_valid_o, core_ready_o, busy_o);
        end
        n_cmp++;
        if (res_signal_o !== RS) begin
            n_err++;
            $display("FAIL reset_res_sig got=%h want=%h", res_signal_o, RS);
        end
        n_cmp++;
        if (dut.u_tags.count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_tags got=%0d want=0", dut.u_tags.count);
        end
        @(negedge clk_i);
        quiet_inputs();
        rst_i = 1'b0;
    endtask

    task automatic test_both();
        logic [SAMPLE_W-1:0] exp_sig;
        @(negedge clk_i);
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        core_ready_i = 1'b1;
        res_ready_i  = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready_o, req1_ready_o, core_valid_o, busy_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL both_grant_cycle got=%b%b%b%b want=0000",
                     req0_ready_o, req1_ready_o, core_valid_o, busy_o);
        end
        for (int f = 0; f < 2; f++) begin
            for (int b = 1; b <= 8; b++) begin
                @(negedge clk_i);
                req0_signal_i = S0 + SAMPLE_W'(b);
                req1_signal_i = S1 + SAMPLE_W'(b);
                exp_sig = (f == 0) ? req0_signal_i : req1_signal_i;
                #1;
                n_cmp++;
                if ({req0_ready_o, req1_ready_o, core_valid_o, busy_o}
                    !== ((f == 0) ? 4'b1011 : 4'b0111)) begin
                    n_err++;
                    $display("FAIL both_stream f%0d b%0d got=%b%b%b%b", f, b,
                             req0_ready_o, req1_ready_o, core_valid_o, busy_o);
                end
                n_cmp++;
                if (core_signal_o !== exp_sig) begin
                    n_err++;
                    $display("FAIL both_sig f%0d b%0d got=%h want=%h",
                             f, b, core_signal_o, exp_sig);
                end
            end
            if (f == 0) begin
                @(negedge clk_i);
                #1;
                n_cmp++;
                if ({req0_ready_o, req1_ready_o, core_valid_o} !== 3'b000) begin
                    n_err++;
                    $display("FAIL both_regrant_cycle got=%b%b%b want=000",
                             req0_ready_o, req1_ready_o, core_valid_o);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            req0_valid_i  = 1'b0;
            req1_valid_i  = 1'b0;
            core_valid_i  = 1'b1;
            core_signal_i = RS + SAMPLE_W'(i);
            #1;
            n_cmp++;
            if ({res_valid_o, core_ready_o, res_id_o} !== {2'b11, i >= 8}) begin
                n_err++;
                $display("FAIL both_res r%0d got=%b%b%b want=11%b", i,
                         res_valid_o, core_ready_o, res_id_o, i >= 8);
            end
            n_cmp++;
            if (res_signal_o !== RS + SAMPLE_W'(i)) begin
                n_err++;
                $display("FAIL both_res_sig r%0d got=%h want=%h",
                         i, res_signal_o, RS + SAMPLE_W'(i));
            end
        end
        @(negedge clk_i);
        #1;
        n_cmp++;
        if ({res_valid_o, core_ready_o, busy_o} !== 3'b000) begin
            n_err++;
            $display("FAIL both_drained got=%b%b%b want=000",
                     res_valid_o, core_ready_o, busy_o);
        end
        core_valid_i = 1'b0;
    endtask

    task automatic test_only_req1();
        @(negedge clk_i);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
            n_err++;
            $display("FAIL r1_grant_cycle got=%b%b want=00",
                     req0_ready_o, req1_ready_o);
        end
        for (int b = 1; b <= 8; b++) begin
            @(negedge clk_i);
            req1_signal_i = S1 + SAMPLE_W'(b + 16);
            #1;
            n_cmp++;
            if ({req0_ready_o, req1_ready_o, core_valid_o} !== 3'b011) begin
                n_err++;
                $display("FAIL r1_stream b%0d got=%b%b%b want=011", b,
                         req0_ready_o, req1_ready_o, core_valid_o);
            end
            n_cmp++;
            if (core_signal_o !== S1 + SAMPLE_W'(b + 16)) begin
                n_err++;
                $display("FAIL r1_sig b%0d got=%h want=%h",
                         b, core_signal_o, S1 + SAMPLE_W'(b + 16));
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            req1_valid_i = 1'b0;
            core_valid_i = 1'b1;
            #1;
            n_cmp++;
            if ({res_id_o, req0_ready_o} !== 2'b10) begin
                n_err++;
                $display("FAIL r1_res r%0d got=%b%b want=10",
                         i, res_id_o, req0_ready_o);
            end
        end
        @(negedge clk_i);
        #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL r1_busy got=%b want=0", busy_o);
        end
        core_valid_i = 1'b0;
    endtask

    task automatic test_gap();
        logic [10:0] pat;
        pat = 11'b111111_000_11;
        @(negedge clk_i);
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk_i);
            req0_valid_i = pat[c];
            #1;
            n_cmp++;
            if ({req0_ready_o, req1_ready_o, core_valid_o}
                !== {2'b10, pat[c]}) begin
                n_err++;
                $display("FAIL gap_stream c%0d got=%b%b%b want=10%b", c,
                         req0_ready_o, req1_ready_o, core_valid_o, pat[c]);
            end
        end
        @(negedge clk_i);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready_o, req1_ready_o, dut.u_tags.count} !== 5'b00_001) begin
            n_err++;
            $display("FAIL gap_end got=%b%b cnt=%0d want=00 cnt=1",
                     req0_ready_o, req1_ready_o, dut.u_tags.count);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            core_valid_i = 1'b1;
            #1;
            n_cmp++;
            if ({res_valid_o, res_id_o} !== 2'b10) begin
                n_err++;
                $display("FAIL gap_res r%0d got=%b%b want=10",
                         i, res_valid_o, res_id_o);
            end
        end
        @(negedge clk_i);
        core_valid_i = 1'b0;
    endtask

    task automatic test_full();
        @(negedge clk_i);
        res_ready_i  = 1'b0;
        core_valid_i = 1'b0;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        for (int c = 1; c < 36; c++) begin
            @(negedge clk_i);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (c >= 2) begin
                core_valid_i = 1'b1;
                res_ready_i  = 1'b1;
            end
            #1;
            n_cmp++;
            if ({req0_ready_o, req1_ready_o, core_valid_o, busy_o} !== 4'b0001
                || dut.u_tags.count !== 3'd4) begin
                n_err++;
                $display("FAIL full_block c%0d got=%b%b%b%b cnt=%0d want=0001 cnt=4",
                         c, req0_ready_o, req1_ready_o, core_valid_o, busy_o,
                         dut.u_tags.count);
            end
            if (c == 2) begin
                n_cmp++;
                if ({res_valid_o, res_id_o} !== 2'b11) begin
                    n_err++;
                    $display("FAIL full_head got=%b%b want=11",
                             res_valid_o, res_id_o);
                end
            end
        end
        @(negedge clk_i);
        core_valid_i = 1'b0;
        res_ready_i  = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready_o, req1_ready_o, dut.u_tags.count} !== 5'b00_011) begin
            n_err++;
            $display("FAIL full_popped got=%b%b cnt=%0d want=00 cnt=3",
                     req0_ready_o, req1_ready_o, dut.u_tags.count);
        end
    endtask

    task automatic test_coincide();
        for (int b = 1; b <= 8; b++) begin
            @(negedge clk_i);
            core_valid_i = 1'b1;
            res_ready_i  = 1'b1;
            #1;
            n_cmp++;
            if ({req1_ready_o, core_valid_o, res_valid_o, res_id_o} !== 4'b1110
                || dut.u_tags.count !== 3'd4) begin
                n_err++;
                $display("FAIL coin_beat b%0d got=%b%b%b%b cnt=%0d want=1110 cnt=4",
                         b, req1_ready_o, core_valid_o, res_valid_o, res_id_o,
                         dut.u_tags.count);
            end
        end
        @(negedge clk_i);
        core_valid_i = 1'b0;
        res_ready_i  = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
            n_err++;
            $display("FAIL coin_idle got=%b%b want=00",
                     req0_ready_o, req1_ready_o);
        end
        @(negedge clk_i);
        #1;
        n_cmp++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10
            || dut.u_tags.count !== 3'd4) begin
            n_err++;
            $display("FAIL coin_regrant got=%b%b cnt=%0d want=10 cnt=4",
                     req0_ready_o, req1_ready_o, dut.u_tags.count);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        rst_i = 1'b1;
        quiet_inputs();
        @(negedge clk_i);
        rst_i        = 1'b0;
        core_ready_i = 1'b1;
        req0_valid_i = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk_i);
        end
        req1_valid_i = 1'b1;
        for (int b = 1; b <= 5; b++) begin
            @(negedge clk_i);
        end
        #1;
        n_cmp++;
        if ({req0_ready_o, req1_ready_o} !== 2'b01) begin
            n_err++;
            $display("FAIL rmid_pre got=%b%b want=01",
                     req0_ready_o, req1_ready_o);
        end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({core_valid_o, req0_ready_o, req1_ready_o, res_valid_o,
             core_ready_o, busy_o} !== 6'b0 || dut.u_tags.count !== 3'd0) begin
            n_err++;
            $display("FAIL rmid_reset got=%b%b%b%b%b%b cnt=%0d want=000000 cnt=0",
                     core_valid_o, req0_ready_o, req1_ready_o, res_valid_o,
                     core_ready_o, busy_o, dut.u_tags.count);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
            n_err++;
            $display("FAIL rmid_grant_cycle got=%b%b want=00",
                     req0_ready_o, req1_ready_o);
        end
        for (int b = 1; b <= 8; b++) begin
            @(negedge clk_i);
            #1;
            n_cmp++;
            if ({req0_ready_o, req1_ready_o, core_valid_o} !== 3'b101) begin
                n_err++;
                $display("FAIL rmid_stream b%0d got=%b%b%b want=101", b,
                         req0_ready_o, req1_ready_o, core_valid_o);
            end
        end
        @(negedge clk_i);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready_o, dut.u_tags.count} !== 4'b0_001) begin
            n_err++;
            $display("FAIL rmid_end got=%b cnt=%0d want=0 cnt=1",
                     req0_ready_o, dut.u_tags.count);
        end
    endtask

    initial begin
        test_reset();
        test_both();
        test_only_req1();
        test_gap();
        test_full();
        test_coincide();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_frame_arbiter.md
FFT_FRAME_ARBITER -- requirements
Module: fft_frame_arbiter

Interface
REQ-001 Parameter FRAME_LEN, default 8, SHALL be the samples per FFT frame (3-stage radix-2 core).
REQ-002 Parameter TAG_DEPTH, default 4, SHALL be the maximum frames in flight inside the core.
REQ-003 Ports SHALL be exactly these (name, direction, width, meaning):
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- req0_signal_i  in  50  requester 0 sample.
- req0_valid_i  in  1  requester 0 valid.
- req0_ready_o  out  1  requester 0 ready.
- req1_signal_i  in  50  requester 1 sample.
- req1_valid_i  in  1  requester 1 valid.
- req1_ready_o  out  1  requester 1 ready.
- core_signal_o  out  50  sample to core.
- core_valid_o  out  1  valid to core.
- core_ready_i  in  1  core ready.
- core_signal_i  in  50  core result.
- core_valid_i  in  1  core result valid.
- core_ready_o  out  1  ready to core.
- res_signal_o  out  50  routed result.
- res_valid_o  out  1  routed result valid.
- res_id_o  out  1  requester that owns the current result.
- res_ready_i  in  1  result consumer ready.
- busy_o  out  1  high while a frame streams or any tag is outstanding.

Function
REQ-004 Input FSM SHALL have two states: IDLE and STREAM.
REQ-005 In IDLE with tag FIFO not full, the arbiter SHALL grant the round-robin-preferred requester if it is valid, else the other if it is valid; a grant pushes the requester id into the tag FIFO and moves to STREAM.
REQ-006 No sample SHALL transfer in the grant cycle, and both reqX_ready_o SHALL be 0 in IDLE.
REQ-007 In STREAM: core_signal_o/core_valid_o SHALL mirror the granted requester's signal/valid, its ready SHALL equal core_ready_i, and the other requester's ready SHALL be 0.
REQ-008 A beat counter SHALL count core_valid_o && core_ready_i; on beat FRAME_LEN it SHALL clear, the FSM SHALL return to IDLE, and the preference SHALL flip to the other requester.
REQ-009 Frames SHALL be atomic: no re-arbitration mid-frame, regardless of the granted requester's valid gaps.
REQ-010 With the tag FIFO full, IDLE SHALL grant nothing until a pop occurs.
REQ-011 Output path: res_signal_o = core_signal_i; res_valid_o = core_valid_i && tag_nonempty; core_ready_o = res_ready_i && tag_nonempty; res_id_o = FIFO head.
REQ-012 An output beat counter SHALL count res_valid_o && res_ready_i; on beat FRAME_LEN it SHALL clear and pop the tag FIFO.
REQ-013 A simultaneous push and pop SHALL leave the occupancy unchanged; FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-014 Samples SHALL pass unmodified, with no width change and zero added latency on either path (combinational muxing only).
REQ-015 busy_o SHALL be 1 when the state is STREAM or the tag count is greater than 0.

Reset
REQ-016 rst_i asserted SHALL immediately force IDLE, preference to requester 0, both counters and the tag FIFO to empty, and all valid/ready outputs plus busy_o to 0, including mid-frame.
REQ-017 After reset, the data outputs SHALL be 0 or the mux of current inputs, and SHALL never be X-driven.

Structure
REQ-018 A shared package fft_pkg SHALL hold SAMPLE_W=50, FRAME_LEN, TAG_DEPTH and the FSM state enum.
REQ-019 The tag FIFO SHALL be one sub-module, fft_tag_fifo (1-bit wide, TAG_DEPTH deep, push/pop/full/empty).

Verification
REQ-020 Both requesters valid after reset -> req0 frame of 8 beats, then req1 frame of 8 beats; res_id_o reads 0 for the first 8 results and 1 for the next 8.
REQ-021 Only req1 valid -> req1 granted although req0 is preferred; req0_ready_o stays 0 throughout.
REQ-022 Granted requester drops valid for 3 cycles mid-frame while the other is valid -> no switch; the frame completes at 8 beats.
REQ-023 Core output held off, 4 frames pushed -> 5th grant blocked; one 8-beat result drain -> grant in the next IDLE cycle.
REQ-024 Last input beat and last result beat in the same cycle with the FIFO full -> occupancy stays 4 and a new grant is allowed.
REQ-025 rst_i pulsed at beat 5 of a frame -> all outputs 0 and FIFO empty; the next frame starts at beat 1 with req0 preferred.
